// File: rtl/sine_voice_scheduler_pkg.sv
// Shared constants and state encoding for the time-shared sine voice scheduler.
package sine_voice_scheduler_pkg;

    localparam int PHASE_W  = 22;
    localparam int STEP_W   = 20;
    localparam int ROM_AW   = 10;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sine_quadrant_fold.sv
// Maps the top 12 phase bits onto a quarter-wave ROM address plus a negate flag.
module sine_quadrant_fold
    import sine_voice_scheduler_pkg::*;
(
    input  logic [ROM_AW+1:0] phase_hi,
    output logic [ROM_AW-1:0] addr,
    output logic              negate
);

    logic [1:0]        quadrant;
    logic [ROM_AW-1:0] index;

    assign quadrant = phase_hi[ROM_AW+1:ROM_AW];
    assign index    = phase_hi[ROM_AW-1:0];

    // Odd quadrants walk the table backwards; ~index equals 1023 - index.
    assign addr   = quadrant[0] ? ~index : index;
    assign negate = quadrant[1];

endmodule

// File: rtl/sine_voice_scheduler.sv
// Shares one sine ROM across NUM_VOICES phase accumulators and mixes one sample per request.
module sine_voice_scheduler
    import sine_voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int MIX_SHIFT  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         generate_next,
    input  logic [STEP_W*NUM_VOICES-1:0] step_sizes,
    input  logic [NUM_VOICES-1:0]        voice_en,
    input  logic [NUM_VOICES-1:0]        phase_clear,
    output logic [ROM_AW-1:0]            rom_addr,
    input  logic [SAMPLE_W-1:0]          rom_dout,
    output logic [SAMPLE_W-1:0]          sample,
    output logic                         sample_ready,
    output logic                         busy,
    output logic                         overrun
);

    localparam int ACC_W = SAMPLE_W + 2;

    state_t                    state, state_next;
    logic [1:0]                idx;
    logic [PHASE_W-1:0]        phase [NUM_VOICES];
    logic [ROM_AW+1:0]         phase_hi_sel;
    logic                      en_sel;
    logic [ROM_AW-1:0]         fold_addr;
    logic                      fold_neg;
    logic [ROM_AW-1:0]         addr_hold;
    logic                      neg_q;
    logic                      en_q;
    logic                      data_vld;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   dout_ext;
    logic signed [ACC_W-1:0]   contrib;
    logic                      accept;
    logic                      last_slot;

    assign accept    = generate_next && (state == IDLE);
    assign last_slot = (idx == 2'(NUM_VOICES - 1));
    assign busy      = (state != IDLE);
    assign rom_addr  = (state == ISSUE) ? fold_addr : addr_hold;

    always_comb begin
        phase_hi_sel = '0;
        en_sel       = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (idx == 2'(i)) begin
                phase_hi_sel = phase[i][PHASE_W-1:PHASE_W-ROM_AW-2];
                en_sel       = voice_en[i];
            end
        end
    end

    sine_quadrant_fold u_fold (
        .phase_hi (phase_hi_sel),
        .addr     (fold_addr),
        .negate   (fold_neg)
    );

    // neg_q/en_q belong to the slot issued last cycle, whose data arrives now.
    assign dout_ext = {{(ACC_W-SAMPLE_W){rom_dout[SAMPLE_W-1]}}, rom_dout};

    always_comb begin
        contrib = '0;
        if (data_vld && en_q) begin
            contrib = neg_q ? -dout_ext : dout_ext;
        end
    end

    assign acc_sum = acc + contrib;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (phase_clear[i]) begin
                    phase[i] <= '0;
                end else if (accept && voice_en[i]) begin
                    phase[i] <= phase[i] + {2'b00, step_sizes[STEP_W*i +: STEP_W]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (generate_next) state_next = ISSUE;
            ISSUE:   if (last_slot) state_next = DRAIN;
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= '0;
            acc          <= '0;
            addr_hold    <= '0;
            neg_q        <= 1'b0;
            en_q         <= 1'b0;
            data_vld     <= 1'b0;
            sample       <= '0;
            sample_ready <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_ready <= 1'b0;
            data_vld     <= (state == ISSUE);
            if (generate_next && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (generate_next) begin
                        idx <= '0;
                        acc <= '0;
                    end
                end
                ISSUE: begin
                    idx       <= idx + 2'd1;
                    addr_hold <= fold_addr;
                    neg_q     <= fold_neg;
                    en_q      <= en_sel;
                    acc       <= acc_sum;
                end
                DRAIN: begin
                    acc          <= acc_sum;
                    sample       <= SAMPLE_W'(acc_sum >>> MIX_SHIFT);
                    sample_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Directed table-driven bench for sine_voice_scheduler with an identity ROM model.
module tb_sine_voice_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        generate_next;
    logic [59:0] step_sizes;
    logic [2:0]  voice_en;
    logic [2:0]  phase_clear;
    logic [9:0]  rom_addr;
    logic [15:0] rom_dout;
    logic [15:0] sample;
    logic        sample_ready;
    logic        busy;
    logic        overrun;

    int n_vec  = 0;
    int n_miss = 0;

    int cap_addr   [0:15];
    int cap_sample [0:15];
    int cap_ready  [0:15];
    int cap_busy   [0:15];
    int cap_ovr    [0:15];

    typedef struct {
        logic [59:0] steps;
        logic [2:0]  en;
        logic [2:0]  clr;
        int          a0;
        int          a1;
        int          a2;
        int          smp;
    } vec_t;

    vec_t vecs [10];

    sine_voice_scheduler #(.NUM_VOICES(3), .MIX_SHIFT(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .generate_next (generate_next),
        .step_sizes    (step_sizes),
        .voice_en      (voice_en),
        .phase_clear   (phase_clear),
        .rom_addr      (rom_addr),
        .rom_dout      (rom_dout),
        .sample        (sample),
        .sample_ready  (sample_ready),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_dout <= {6'b0, rom_addr};

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Caller has set up cycle 0; gen_mask[c] drives generate_next during cycle c.
    task automatic run_cycles(input int ncyc, input logic [15:0] gen_mask);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            generate_next  = gen_mask[c];
            cap_addr[c]    = int'(rom_addr);
            cap_sample[c]  = int'($signed(sample));
            cap_ready[c]   = int'(sample_ready);
            cap_busy[c]    = int'(busy);
            cap_ovr[c]     = int'(overrun);
        end
    endtask

    initial begin
        vecs[0] = '{60'h00000_00000_40000, 3'b001, 3'b000,  256,    0,    0,   64};
        vecs[1] = '{60'h00000_00000_FFFFF, 3'b001, 3'b001,    0,    0,    0,    0};
        vecs[2] = '{60'h00000_00000_FFFFF, 3'b001, 3'b000, 1023,    0,    0,  255};
        vecs[3] = '{60'h00000_00000_FFFFF, 3'b001, 3'b000,    0,    0,    0,    0};
        vecs[4] = '{60'h00000_00000_FFFFF, 3'b001, 3'b000, 1023,    0,    0, -256};
        vecs[5] = '{60'h00000_00000_00000, 3'b000, 3'b111,    0,    0,    0,    0};
        vecs[6] = '{60'hC0000_80000_40000, 3'b111, 3'b000,  256,  512,  768,  384};
        vecs[7] = '{60'hC0000_80000_40000, 3'b111, 3'b000,  512, 1023,  511,  511};
        vecs[8] = '{60'hC0000_80000_40000, 3'b101, 3'b000,  768, 1023,  256,  128};
        vecs[9] = '{60'hC0000_80000_40000, 3'b111, 3'b010, 1023,    0, 1023,    0};

        reset = 1'b1; generate_next = 1'b0; step_sizes = '0; voice_en = '0; phase_clear = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rom_addr", int'(rom_addr), 0);
        check("reset sample", int'(sample), 0);
        check("reset sample_ready", int'(sample_ready), 0);
        check("reset busy", int'(busy), 0);
        check("reset overrun", int'(overrun), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            step_sizes = vecs[i].steps; voice_en = vecs[i].en; phase_clear = vecs[i].clr;
            generate_next = 1'b1;
            run_cycles(7, 16'h0000);
            phase_clear = '0;
            check($sformatf("v%0d slot0 addr", i), cap_addr[1], vecs[i].a0);
            check($sformatf("v%0d slot1 addr", i), cap_addr[2], vecs[i].a1);
            check($sformatf("v%0d slot2 addr", i), cap_addr[3], vecs[i].a2);
            check($sformatf("v%0d sample", i), cap_sample[5], vecs[i].smp);
            for (int c = 1; c <= 7; c++) begin
                check($sformatf("v%0d ready c%0d", i, c), cap_ready[c], (c == 5) ? 1 : 0);
                check($sformatf("v%0d busy c%0d", i, c), cap_busy[c], (c >= 1 && c <= 4) ? 1 : 0);
            end
        end
        check("overrun clear after table", int'(overrun), 0);

        // Drop a request in cycle 2, then issue one back-to-back with sample_ready.
        step_sizes = 60'h00000_00000_40000; voice_en = 3'b001;
        generate_next = 1'b1;
        run_cycles(11, 16'b0000_0000_0010_0100);
        check("ovr overrun before drop", cap_ovr[2], 0);
        check("ovr overrun set", cap_ovr[3], 1);
        check("ovr first addr", cap_addr[1], 767);
        check("ovr first ready", cap_ready[5], 1);
        check("ovr first sample", cap_sample[5], 191);
        check("ovr second busy", cap_busy[6], 1);
        check("ovr second addr", cap_addr[6], 511);
        check("ovr second ready c9", cap_ready[9], 0);
        check("ovr second ready", cap_ready[10], 1);
        check("ovr second sample", cap_sample[10], 127);
        check("ovr sticky", cap_ovr[11], 1);

        // Abort mid-sequence with reset in cycle 3.
        generate_next = 1'b1;
        run_cycles(2, 16'h0000);
        check("rst busy before", cap_busy[2], 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst rom_addr", int'(rom_addr), 0);
        check("rst sample", int'(sample), 0);
        check("rst sample_ready", int'(sample_ready), 0);
        check("rst busy", int'(busy), 0);
        check("rst overrun", int'(overrun), 0);
        reset = 1'b0;
        run_cycles(4, 16'h0000);
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("rst no ready c%0d", c), cap_ready[c], 0);
        end

        // Phases must restart from zero after the reset.
        step_sizes = 60'hC0000_80000_40000; voice_en = 3'b111;
        generate_next = 1'b1;
        run_cycles(6, 16'h0000);
        check("post rst slot0", cap_addr[1], 256);
        check("post rst slot1", cap_addr[2], 512);
        check("post rst slot2", cap_addr[3], 768);
        check("post rst ready", cap_ready[5], 1);
        check("post rst sample", cap_sample[5], 384);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
